// File: rtl/spi_slave_sync_pkg.sv
// Shared definitions for the oversampled SPI slave: mode encoding and helpers.
// A mode packs CPOL in bit 1 and CPHA in bit 0.
package spi_slave_sync_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  function automatic spi_mode_e make_mode(input bit cpol, input bit cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  function automatic bit mode_cpol(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[1];
  endfunction

  function automatic bit mode_cpha(input spi_mode_e m);
    logic [1:0] v;
    v = m;
    return v[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a history flop; level and edge strobes are
// all registered and aligned to the same clk cycle.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      hist_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
    end
  end

  assign level = hist_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the clk domain, all four modes, either bit order,
// valid/ready word streams with underrun and overrun strobes.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b1,
  parameter bit               SS          = 1'b0,
  parameter bit               LSB_FIRST   = 1'b0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_FILL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ss,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             active,
  output logic             tx_underrun,
  output logic             rx_overrun,
  output logic             frame_end
);

  localparam int        BW           = $clog2(WIDTH);
  localparam spi_mode_e MODE         = make_mode(CPOL, CPHA);
  localparam bit        SAMPLE_TRAIL = mode_cpha(MODE);
  localparam bit        SCLK_IDLE    = mode_cpol(MODE);

  logic sel, sel_rise, sel_fall;
  logic sclk_away, lead_raw, trail_raw;
  logic mosi_s, mosi_rise, mosi_fall;

  // Pins are pre-inverted so the synchronised levels read "selected" and
  // "SCLK away from idle"; both then reset to the inactive state.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (ss ^ SS),
    .level   (sel),
    .rise    (sel_rise),
    .fall    (sel_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (sclk ^ SCLK_IDLE),
    .level   (sclk_away),
    .rise    (lead_raw),
    .fall    (trail_raw)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (mosi),
    .level   (mosi_s),
    .rise    (mosi_rise),
    .fall    (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_away, mosi_rise, mosi_fall};

  logic             lead, trail, sample_edge, shift_edge;
  logic             load, shift, word_done, tx_fire;
  logic [BW-1:0]    bitcnt;
  logic [WIDTH-1:0] tx_buf, tx_shift, tx_next;
  logic [WIDTH-1:0] rx_shift, rx_next;
  logic             full;

  assign lead        = lead_raw & sel;
  assign trail       = trail_raw & sel;
  assign sample_edge = SAMPLE_TRAIL ? trail : lead;
  assign shift_edge  = SAMPLE_TRAIL ? lead : trail;
  assign load        = (shift_edge & (bitcnt == '0)) | (~SAMPLE_TRAIL & sel_rise);
  assign shift       = shift_edge & ~load;
  assign word_done   = sample_edge & (bitcnt == BW'(WIDTH - 1));
  assign tx_fire     = tx_valid & ~full;

  assign tx_ready  = ~full;
  assign active    = sel;
  assign frame_end = sel_fall;

  always_comb begin
    tx_next = tx_shift;
    if (load) begin
      tx_next = full ? tx_buf : TX_FILL;
    end else if (shift) begin
      tx_next = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
    end
  end

  always_comb begin
    rx_next = LSB_FIRST ? {mosi_s, rx_shift[WIDTH-1:1]} : {rx_shift[WIDTH-2:0], mosi_s};
  end

  // TX side: a write arriving in the same cycle as a load that found the
  // buffer empty still lands, because the write assignment comes last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf      <= '0;
      full        <= 1'b0;
      tx_shift    <= '0;
      miso        <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (load) begin
        full <= 1'b0;
        if (!full) begin
          tx_underrun <= 1'b1;
        end
      end
      if (tx_fire) begin
        tx_buf <= tx_data;
        full   <= 1'b1;
      end
      if (load || shift) begin
        tx_shift <= tx_next;
        miso     <= LSB_FIRST ? tx_next[0] : tx_next[WIDTH-1];
      end
    end
  end

  // RX side: a deselect clears the count and the partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (!sel) begin
        bitcnt   <= '0;
        rx_shift <= '0;
      end else if (sample_edge) begin
        rx_shift <= rx_next;
        bitcnt   <= (bitcnt == BW'(WIDTH - 1)) ? '0 : bitcnt + 1'b1;
      end
      if (word_done) begin
        if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: four instances (mode 1 / 8-bit / MSB first and
// modes 0, 2, 3 / 16-bit / LSB first) driven by a bit-level SPI master.
module tb_spi_slave_sync;
  import spi_slave_sync_pkg::*;

  localparam int N = 4;
  localparam int H = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        ss_p[N], sclk_p[N], mosi_p[N], miso_p[N];
  logic [15:0] txd[N];
  logic        tx_valid_p[N], tx_ready_p[N], rx_valid_p[N], rx_ready_p[N];
  logic        active_p[N], und_p[N], ovr_p[N], fe_p[N];
  logic [7:0]  rx8;
  logic [15:0] rx_w[N];

  int width_t[N] = '{8, 16, 16, 16};
  bit cpol_t[N]  = '{mode_cpol(SPI_MODE1), mode_cpol(SPI_MODE0), mode_cpol(SPI_MODE2), mode_cpol(SPI_MODE3)};
  bit cpha_t[N]  = '{mode_cpha(SPI_MODE1), mode_cpha(SPI_MODE0), mode_cpha(SPI_MODE2), mode_cpha(SPI_MODE3)};
  bit lsb_t[N]   = '{1'b0, 1'b1, 1'b1, 1'b1};

  int n_checks = 0;
  int n_errors = 0;
  int n_fe[N], n_und[N], n_ovr[N], n_rx[N];
  logic [19:0] exp_q[$];

  assign rx_w[0] = {8'h00, rx8};

  spi_slave_sync #(.WIDTH(8), .CPOL(mode_cpol(SPI_MODE1)), .CPHA(mode_cpha(SPI_MODE1)), .LSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .ss(ss_p[0]), .sclk(sclk_p[0]), .mosi(mosi_p[0]), .miso(miso_p[0]),
    .tx_data(txd[0][7:0]), .tx_valid(tx_valid_p[0]), .tx_ready(tx_ready_p[0]),
    .rx_data(rx8), .rx_valid(rx_valid_p[0]), .rx_ready(rx_ready_p[0]), .active(active_p[0]),
    .tx_underrun(und_p[0]), .rx_overrun(ovr_p[0]), .frame_end(fe_p[0]));

  spi_slave_sync #(.WIDTH(16), .CPOL(mode_cpol(SPI_MODE0)), .CPHA(mode_cpha(SPI_MODE0)), .LSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .ss(ss_p[1]), .sclk(sclk_p[1]), .mosi(mosi_p[1]), .miso(miso_p[1]),
    .tx_data(txd[1]), .tx_valid(tx_valid_p[1]), .tx_ready(tx_ready_p[1]),
    .rx_data(rx_w[1]), .rx_valid(rx_valid_p[1]), .rx_ready(rx_ready_p[1]), .active(active_p[1]),
    .tx_underrun(und_p[1]), .rx_overrun(ovr_p[1]), .frame_end(fe_p[1]));

  spi_slave_sync #(.WIDTH(16), .CPOL(mode_cpol(SPI_MODE2)), .CPHA(mode_cpha(SPI_MODE2)), .LSB_FIRST(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ss(ss_p[2]), .sclk(sclk_p[2]), .mosi(mosi_p[2]), .miso(miso_p[2]),
    .tx_data(txd[2]), .tx_valid(tx_valid_p[2]), .tx_ready(tx_ready_p[2]),
    .rx_data(rx_w[2]), .rx_valid(rx_valid_p[2]), .rx_ready(rx_ready_p[2]), .active(active_p[2]),
    .tx_underrun(und_p[2]), .rx_overrun(ovr_p[2]), .frame_end(fe_p[2]));

  spi_slave_sync #(.WIDTH(16), .CPOL(mode_cpol(SPI_MODE3)), .CPHA(mode_cpha(SPI_MODE3)), .LSB_FIRST(1'b1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .ss(ss_p[3]), .sclk(sclk_p[3]), .mosi(mosi_p[3]), .miso(miso_p[3]),
    .tx_data(txd[3]), .tx_valid(tx_valid_p[3]), .tx_ready(tx_ready_p[3]),
    .rx_data(rx_w[3]), .rx_valid(rx_valid_p[3]), .rx_ready(rx_ready_p[3]), .active(active_p[3]),
    .tx_underrun(und_p[3]), .rx_overrun(ovr_p[3]), .frame_end(fe_p[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe counters and RX scoreboard: a word is consumed on rx_valid & rx_ready.
  always @(negedge clk) begin
    logic [19:0] e;
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (fe_p[i])  n_fe[i]++;
        if (und_p[i]) n_und[i]++;
        if (ovr_p[i]) n_ovr[i]++;
        if (rx_valid_p[i] && rx_ready_p[i]) begin
          n_rx[i]++;
          if (exp_q.size() == 0) begin
            check("rx_unexpected", {12'h0, i[3:0], rx_w[i]}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            check("rx_word", {12'h0, i[3:0], rx_w[i]}, {12'h0, e});
          end
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_on(input int id);
    ss_p[id] = 1'b1;
    wait_clk(10);
  endtask

  task automatic ss_off(input int id);
    wait_clk(H);
    ss_p[id] = 1'b0;
    wait_clk(12);
  endtask

  task automatic tx_write(input int id, input logic [15:0] data);
    bit ok;
    ok = 1'b0;
    txd[id] = data;
    @(negedge clk);
    tx_valid_p[id] = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (tx_ready_p[id]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    tx_valid_p[id] = 1'b0;
    check("tx_accept", {31'h0, ok}, 32'h1);
  endtask

  task automatic xfer(input int id, input logic [15:0] dout, input int nbits, output logic [15:0] din);
    int k;
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      k = lsb_t[id] ? i : width_t[id] - 1 - i;
      if (!cpha_t[id]) begin
        mosi_p[id] = dout[k];
        wait_clk(H);
        sclk_p[id] = ~cpol_t[id];
        din[k] = miso_p[id];
        wait_clk(H);
        sclk_p[id] = cpol_t[id];
      end else begin
        sclk_p[id] = ~cpol_t[id];
        mosi_p[id] = dout[k];
        wait_clk(H);
        sclk_p[id] = cpol_t[id];
        din[k] = miso_p[id];
        wait_clk(H);
      end
    end
  endtask

  initial begin
    logic [15:0] d1, d2;
    int s_fe, s_rx, s_und, s_ovr;
    for (int i = 0; i < N; i++) begin
      ss_p[i] = 1'b0;
      sclk_p[i] = cpol_t[i];
      mosi_p[i] = 1'b0;
      txd[i] = '0;
      tx_valid_p[i] = 1'b0;
      rx_ready_p[i] = 1'b1;
      n_fe[i] = 0; n_und[i] = 0; n_ovr[i] = 0; n_rx[i] = 0;
    end
    wait_clk(5);
    for (int i = 0; i < N; i++) begin
      check("rst_tx_ready", {31'h0, tx_ready_p[i]}, 32'h1);
      check("rst_rx_valid", {31'h0, rx_valid_p[i]}, 32'h0);
      check("rst_rx_data", {16'h0, rx_w[i]}, 32'h0);
      check("rst_active", {31'h0, active_p[i]}, 32'h0);
      check("rst_miso", {31'h0, miso_p[i]}, 32'h0);
      check("rst_strobes", {29'h0, und_p[i], ovr_p[i], fe_p[i]}, 32'h0);
    end
    reset_n = 1'b1;
    wait_clk(4);

    // Mode 1 basic exchange
    tx_write(0, 16'h00A5);
    s_fe = n_fe[0]; s_rx = n_rx[0]; s_und = n_und[0];
    exp_q.push_back({4'd0, 16'h003C});
    ss_on(0);
    check("m1_active", {31'h0, active_p[0]}, 32'h1);
    xfer(0, 16'h003C, 8, d1);
    ss_off(0);
    check("m1_miso_word", {16'h0, d1}, 32'h00A5);
    check("m1_rx_data", {16'h0, rx_w[0]}, 32'h003C);
    check("m1_rx_count", n_rx[0] - s_rx, 1);
    check("m1_frame_end", n_fe[0] - s_fe, 1);
    check("m1_no_underrun", n_und[0] - s_und, 0);
    check("m1_inactive", {31'h0, active_p[0]}, 32'h0);

    // Modes 0, 2, 3 with LSB first, 16-bit words
    for (int id = 1; id < N; id++) begin
      tx_write(id, 16'h8001);
      check("wide_buf_full", {31'h0, tx_ready_p[id]}, 32'h0);
      s_fe = n_fe[id];
      exp_q.push_back({id[3:0], 16'h1234});
      ss_on(id);
      xfer(id, 16'h1234, 16, d1);
      ss_off(id);
      check("wide_miso_word", {16'h0, d1}, 32'h8001);
      check("wide_frame_end", n_fe[id] - s_fe, 1);
    end

    // Back-to-back words with nothing buffered
    s_und = n_und[0];
    exp_q.push_back({4'd0, 16'h0069});
    exp_q.push_back({4'd0, 16'h0096});
    ss_on(0);
    xfer(0, 16'h0069, 8, d1);
    xfer(0, 16'h0096, 8, d2);
    ss_off(0);
    check("ur_word1", {16'h0, d1}, 32'h00FF);
    check("ur_word2", {16'h0, d2}, 32'h00FF);
    check("ur_count", n_und[0] - s_und, 2);

    // Overrun: consumer stalled across two words
    rx_ready_p[0] = 1'b0;
    s_ovr = n_ovr[0];
    ss_on(0);
    xfer(0, 16'h0011, 8, d1);
    xfer(0, 16'h0022, 8, d2);
    ss_off(0);
    check("ovr_count", n_ovr[0] - s_ovr, 1);
    check("ovr_rx_data", {16'h0, rx_w[0]}, 32'h0011);
    check("ovr_rx_valid", {31'h0, rx_valid_p[0]}, 32'h1);
    exp_q.push_back({4'd0, 16'h0011});
    rx_ready_p[0] = 1'b1;
    wait_clk(3);
    check("ovr_drained", {31'h0, rx_valid_p[0]}, 32'h0);

    // Deselect after 5 bits, then a full frame
    s_rx = n_rx[0];
    ss_on(0);
    xfer(0, 16'h00F0, 5, d1);
    ss_off(0);
    check("part_no_word", n_rx[0] - s_rx, 0);
    check("part_rx_valid", {31'h0, rx_valid_p[0]}, 32'h0);
    exp_q.push_back({4'd0, 16'h005A});
    ss_on(0);
    xfer(0, 16'h005A, 8, d1);
    ss_off(0);
    check("part_next_count", n_rx[0] - s_rx, 1);
    check("part_next_data", {16'h0, rx_w[0]}, 32'h005A);

    // Reset pulse in the middle of a word
    ss_on(0);
    xfer(0, 16'h00C3, 4, d1);
    tx_write(0, 16'h0077);
    check("pre_rst_full", {31'h0, tx_ready_p[0]}, 32'h0);
    reset_n = 1'b0;
    #2;
    check("mid_rst_tx_ready", {31'h0, tx_ready_p[0]}, 32'h1);
    check("mid_rst_rx_data", {16'h0, rx_w[0]}, 32'h0);
    check("mid_rst_rx_valid", {31'h0, rx_valid_p[0]}, 32'h0);
    check("mid_rst_active", {31'h0, active_p[0]}, 32'h0);
    check("mid_rst_miso", {31'h0, miso_p[0]}, 32'h0);
    ss_p[0] = 1'b0;
    sclk_p[0] = cpol_t[0];
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    tx_write(0, 16'h0096);
    exp_q.push_back({4'd0, 16'h00C3});
    ss_on(0);
    xfer(0, 16'h00C3, 8, d1);
    ss_off(0);
    check("post_rst_miso", {16'h0, d1}, 32'h0096);
    check("post_rst_rx", {16'h0, rx_w[0]}, 32'h00C3);

    wait_clk(4);
    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
